// File: rtl/tx_pulse_seq_ctl_if.sv
// Hop-config handshake between the channel planner and the transmit sequencer.
// The master offers configs with hop_vld/hop_data; the sequencer answers with hop_rdy.
interface tx_pulse_seq_ctl_if;
    logic       hop_vld;
    logic [7:0] hop_data;
    logic       hop_rdy;

    modport master (
        output hop_vld,
        output hop_data,
        input  hop_rdy
    );

    modport slave (
        input  hop_vld,
        input  hop_data,
        output hop_rdy
    );
endinterface

// File: rtl/tx_pulse_seq_ctl.sv
// Per-slot transmit sequencer: PA lead, per-pulse config/settle/gate/gap, PA lag.
// Hop configs come from a small FIFO; an empty FIFO at LOAD or tx_abort ends the slot early.
module tx_pulse_seq_ctl #(
    parameter int SETTLE_CYC = 200,
    parameter int OCCUPY_CYC = 1680,
    parameter int PERIOD_CYC = 2600,
    parameter int PA_LEAD    = 400,
    parameter int PA_LAG     = 200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    logic_clk_in,
    input  logic                    logic_rst_in,
    input  logic                    slot_start,
    input  logic [8:0]              pulse_num,
    input  logic                    tx_abort,
    tx_pulse_seq_ctl_if.slave       hop,
    output logic [7:0]              tx_feq_cfg_out,
    output logic                    cfg_update,
    output logic                    rf_gate,
    output logic                    pa_tx_en,
    output logic                    busy,
    output logic [8:0]              pulse_idx,
    output logic                    underrun_err,
    output logic                    overlap_err
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int GAP_CYC = PERIOD_CYC - 1 - SETTLE_CYC - OCCUPY_CYC;

    typedef enum logic [2:0] {
        S_IDLE, S_PA_ON, S_LOAD, S_SETTLE, S_ON, S_GAP, S_PA_OFF
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [8:0]  num_q, idx_q;
    logic [7:0]  cfg_q;
    logic        ovl_q;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] fcnt, fcnt_nxt;
    logic        rdy_q;
    logic        empty, push, load_ok, abort_take, flush;

    function automatic logic [15:0] reload(input state_t s);
        logic [15:0] r;
        r = '0;
        case (s)
            S_PA_ON:  r = 16'(PA_LEAD - 1);
            S_SETTLE: r = 16'(SETTLE_CYC - 1);
            S_ON:     r = 16'(OCCUPY_CYC - 1);
            S_GAP:    r = 16'(GAP_CYC - 1);
            S_PA_OFF: r = 16'(PA_LAG - 1);
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign empty      = (fcnt == '0);
    assign push       = hop.hop_vld && rdy_q;
    assign abort_take = tx_abort && (state != S_IDLE) && (state != S_PA_OFF);
    // An aborting LOAD does not pop, so the config output keeps its old value.
    assign load_ok    = (state == S_LOAD) && !empty && !tx_abort;
    assign flush      = ((state == S_LOAD) && empty) || abort_take;
    assign hop.hop_rdy = rdy_q;

    always_comb begin
        fcnt_nxt = fcnt;
        if (flush)
            fcnt_nxt = '0;
        else if (push && !load_ok)
            fcnt_nxt = fcnt + 1'b1;
        else if (!push && load_ok)
            fcnt_nxt = fcnt - 1'b1;
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            wp    <= '0;
            rp    <= '0;
            fcnt  <= '0;
            rdy_q <= 1'b0;
        end else begin
            fcnt  <= fcnt_nxt;
            rdy_q <= (fcnt_nxt != (AW+1)'(FIFO_DEPTH));
            if (flush) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (push)
                    wp <= wp + 1'b1;
                if (load_ok)
                    rp <= rp + 1'b1;
            end
        end
    end

    always_ff @(posedge logic_clk_in) begin
        if (push)
            mem[wp] <= hop.hop_data;
    end

    always_ff @(posedge logic_clk_in or posedge logic_rst_in) begin
        if (logic_rst_in) begin
            state <= S_IDLE;
            cnt   <= '0;
            num_q <= '0;
            idx_q <= '0;
            cfg_q <= 8'h84;
            ovl_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every timed state reloads on entry and leaves when the count hits zero.
            if (state_nxt != state)
                cnt <= reload(state_nxt);
            else if (cnt != 16'd0)
                cnt <= cnt - 16'd1;
            if ((state == S_IDLE) && (state_nxt == S_PA_ON)) begin
                num_q <= pulse_num;
                idx_q <= '0;
            end else if ((state == S_GAP) && (state_nxt == S_LOAD)) begin
                idx_q <= idx_q + 9'd1;
            end
            if (load_ok)
                cfg_q <= mem[rp];
            ovl_q <= slot_start && (state != S_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (slot_start && !tx_abort && (pulse_num != 9'd0)) state_nxt = S_PA_ON;
            S_PA_ON:  if (cnt == 16'd0) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = empty ? S_PA_OFF : S_SETTLE;
            S_SETTLE: if (cnt == 16'd0) state_nxt = S_ON;
            S_ON:     if (cnt == 16'd0) state_nxt = S_GAP;
            S_GAP:    if (cnt == 16'd0) state_nxt = (idx_q == num_q - 9'd1) ? S_PA_OFF : S_LOAD;
            S_PA_OFF: if (cnt == 16'd0) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_take)
            state_nxt = S_PA_OFF;
    end

    always_comb begin
        rf_gate        = (state == S_ON);
        pa_tx_en       = (state != S_IDLE);
        busy           = (state != S_IDLE);
        cfg_update     = (state == S_SETTLE) && (cnt == 16'(SETTLE_CYC - 1));
        underrun_err   = (state == S_LOAD) && empty;
        overlap_err    = ovl_q;
        tx_feq_cfg_out = cfg_q;
        pulse_idx      = idx_q;
    end
endmodule

// File: tb/tb_tx_pulse_seq_ctl.sv
// Bench for tx_pulse_seq_ctl: directed table, hand-written corner sequences and
// randomized slots checked against a schedule computed from pulse timing arithmetic.
module tb_tx_pulse_seq_ctl;
    localparam int S = 2, O = 4, P = 10, LEAD = 3, LAG = 2, D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slot_start = 1'b0;
    logic       tx_abort = 1'b0;
    logic [8:0] pulse_num = '0;
    logic [7:0] cfg;
    logic       cfg_update, rf_gate, pa_tx_en, busy, underrun_err, overlap_err;
    logic [8:0] pulse_idx;

    tx_pulse_seq_ctl_if hop();

    tx_pulse_seq_ctl #(
        .SETTLE_CYC(S), .OCCUPY_CYC(O), .PERIOD_CYC(P),
        .PA_LEAD(LEAD), .PA_LAG(LAG), .FIFO_DEPTH(D)
    ) dut (
        .logic_clk_in(clk), .logic_rst_in(rst), .slot_start(slot_start),
        .pulse_num(pulse_num), .tx_abort(tx_abort), .hop(hop),
        .tx_feq_cfg_out(cfg), .cfg_update(cfg_update), .rf_gate(rf_gate),
        .pa_tx_en(pa_tx_en), .busy(busy), .pulse_idx(pulse_idx),
        .underrun_err(underrun_err), .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] snap[$];
    logic [7:0] m_cfg = 8'h84;
    int  sc_n, sc_ent, sc_ov, pu, off_nat, off_fin, cut;
    bit  ab_eff;

    typedef struct {
        int n; int ent; logic [7:0] d0; logic [7:0] d1; logic [7:0] d2; int a;
        int exp_idle; int exp_ur; int exp_rises; int exp_rise0; logic [7:0] exp_cfg;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ld(input int p);
        return LEAD + 1 + p * P;
    endfunction

    function automatic bit loaded(input int p);
        return (p < sc_n) && (p < sc_ent) && (ld(p) < cut);
    endfunction

    task automatic push(input logic [7:0] d);
        chk("hop_rdy_before_push", int'(hop.hop_rdy), int'(mq.size() < D));
        hop.hop_vld  = 1'b1;
        hop.hop_data = d;
        tick();
        hop.hop_vld  = 1'b0;
        if (mq.size() < D) mq.push_back(d);
    endtask

    // Slot timeline: cycle 0 drives slot_start, LOAD of pulse p at LEAD+1+p*PERIOD.
    task automatic run_slot(input int n, input int a, input int ov,
                            output int idle_t, output int ur_t, output int rises,
                            output int rise0, output int last_cfg);
        int  t_end, e_idx, e_cfg, nl, e_size;
        bit  e_rf, e_cu, prev_rf;
        sc_n    = n;
        snap    = mq;
        sc_ent  = mq.size();
        pu      = (sc_ent < n) ? sc_ent : -1;
        off_nat = (pu >= 0) ? ld(pu) + 1 : ld(n - 1) + P;
        ab_eff  = (a >= 1) && (a < off_nat);
        off_fin = ab_eff ? a + 1 : off_nat;
        cut     = ab_eff ? a : 32'h3fff_ffff;
        sc_ov   = (ov >= 1 && ov < off_fin + LAG) ? ov : -1;
        t_end   = off_fin + LAG + 1;
        idle_t = -1; ur_t = -1; rises = 0; rise0 = -1; prev_rf = 1'b0;
        e_cfg = int'(m_cfg);
        slot_start = 1'b1;
        pulse_num  = 9'(n);
        tx_abort   = 1'b0;
        for (int t = 1; t <= t_end; t++) begin
            tick();
            e_rf = 1'b0; e_cu = 1'b0; e_idx = 0; e_cfg = int'(m_cfg); nl = 0;
            for (int p = 0; p < n; p++) begin
                if (ld(p) <= t && ld(p) < off_fin) e_idx = p;
                if (loaded(p)) begin
                    if (t >= ld(p) + S + 1 && t <= ld(p) + S + O && t < off_fin) e_rf = 1'b1;
                    if (t == ld(p) + 1) e_cu = 1'b1;
                    if (t >= ld(p) + 1) begin
                        e_cfg = int'(snap[p]);
                        nl++;
                    end
                end
            end
            e_size = ((ab_eff || pu >= 0) && t >= off_fin) ? 0 : sc_ent - nl;
            chk("rf_gate", int'(rf_gate), int'(e_rf));
            chk("pa_tx_en", int'(pa_tx_en), int'(t < off_fin + LAG));
            chk("busy", int'(busy), int'(t < off_fin + LAG));
            chk("cfg_update", int'(cfg_update), int'(e_cu));
            chk("underrun_err", int'(underrun_err),
                int'(pu >= 0 && t == ld(pu) && (!ab_eff || a >= ld(pu))));
            chk("pulse_idx", int'(pulse_idx), e_idx);
            chk("tx_feq_cfg_out", int'(cfg), e_cfg);
            chk("overlap_err", int'(overlap_err), int'(sc_ov >= 1 && t == sc_ov + 1));
            chk("hop_rdy", int'(hop.hop_rdy), int'(e_size < D));
            if (!busy && idle_t < 0) idle_t = t;
            if (underrun_err) ur_t = t;
            if (rf_gate && !prev_rf) begin
                rises++;
                if (rise0 < 0) rise0 = t;
            end
            prev_rf    = rf_gate;
            slot_start = (t == sc_ov);
            pulse_num  = (t == sc_ov) ? 9'd5 : 9'd0;
            tx_abort   = (t == a);
        end
        slot_start = 1'b0;
        tx_abort   = 1'b0;
        pulse_num  = '0;
        last_cfg   = int'(cfg);
        m_cfg      = 8'(e_cfg);
        if (ab_eff || pu >= 0) mq.delete();
        else repeat (n) void'(mq.pop_front());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idle_t, ur_t, rises, rise0, last_cfg;
        logic [7:0] dv;
        hop.hop_vld  = 1'b0;
        hop.hop_data = '0;

        tbl[0] = '{1, 1, 8'h21, 8'h00, 8'h00, -1, 16, -1, 1, 7, 8'h21};
        tbl[1] = '{3, 3, 8'h11, 8'h42, 8'h84, -1, 36, -1, 3, 7, 8'h84};
        tbl[2] = '{3, 1, 8'h5a, 8'h00, 8'h00, -1, 17, 14, 1, 7, 8'h5a};
        tbl[3] = '{1, 1, 8'h33, 8'h00, 8'h00,  8, 11, -1, 1, 7, 8'h33};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_cfg", int'(cfg), 8'h84);
        chk("reset_rf_gate", int'(rf_gate), 0);
        chk("reset_pa_tx_en", int'(pa_tx_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_cfg_update", int'(cfg_update), 0);
        chk("reset_underrun", int'(underrun_err), 0);
        chk("reset_overlap", int'(overlap_err), 0);
        chk("reset_pulse_idx", int'(pulse_idx), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("hop_rdy_after_reset", int'(hop.hop_rdy), 1);

        // slot_start with zero pulses, and slot_start held off by tx_abort, both leave IDLE alone
        slot_start = 1'b1; pulse_num = 9'd0;
        tick();
        slot_start = 1'b0;
        chk("zero_pulse_ignored", int'(busy), 0);
        tick();
        chk("zero_pulse_no_overlap", int'(overlap_err), 0);
        slot_start = 1'b1; pulse_num = 9'd2; tx_abort = 1'b1;
        tick();
        slot_start = 1'b0; tx_abort = 1'b0; pulse_num = 9'd0;
        chk("abort_blocks_start", int'(busy), 0);
        tick();
        chk("abort_blocks_start_2", int'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < tbl[i].ent; k++)
                push((k == 0) ? tbl[i].d0 : (k == 1) ? tbl[i].d1 : tbl[i].d2);
            run_slot(tbl[i].n, tbl[i].a, -1, idle_t, ur_t, rises, rise0, last_cfg);
            chk("tbl_idle_cycle", idle_t, tbl[i].exp_idle);
            chk("tbl_underrun_cycle", ur_t, tbl[i].exp_ur);
            chk("tbl_rf_rises", rises, tbl[i].exp_rises);
            chk("tbl_first_rise", rise0, tbl[i].exp_rise0);
            chk("tbl_final_cfg", last_cfg, int'(tbl[i].exp_cfg));
            tick();
            chk("tbl_hop_rdy_idle", int'(hop.hop_rdy), 1);
        end

        // Five back-to-back pushes into a 4-deep FIFO, then an overlapping slot_start
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
        chk("hop_rdy_full", int'(hop.hop_rdy), 0);
        run_slot(4, -1, 6, idle_t, ur_t, rises, rise0, last_cfg);
        chk("full_last_cfg", last_cfg, 8'hA4);
        chk("overlap_idle_cycle", idle_t, 46);
        tick();
        run_slot(1, -1, -1, idle_t, ur_t, rises, rise0, last_cfg);
        chk("fifth_push_dropped", ur_t, 4);
        tick();

        // Asynchronous reset while the RF gate is open
        push(8'hC1); push(8'hC2); push(8'hC3);
        slot_start = 1'b1; pulse_num = 9'd2;
        tick();
        slot_start = 1'b0; pulse_num = 9'd0;
        repeat (7) tick();
        chk("rf_gate_before_reset", int'(rf_gate), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rf_gate", int'(rf_gate), 0);
        chk("async_rst_pa_tx_en", int'(pa_tx_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_cfg", int'(cfg), 8'h84);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_cfg = 8'h84;
        tick();
        tick();
        chk("hop_rdy_after_mid_reset", int'(hop.hop_rdy), 1);
        run_slot(1, -1, -1, idle_t, ur_t, rises, rise0, last_cfg);
        chk("fifo_empty_after_reset", ur_t, 4);
        tick();

        repeat (30) begin
            int k, n, a, ov;
            k  = $urandom_range(0, 5);
            n  = $urandom_range(1, 4);
            a  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 45));
            ov = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 45)) : -1;
            for (int j = 0; j < k; j++) begin
                dv = 8'($urandom);
                push(dv);
            end
            run_slot(n, a, ov, idle_t, ur_t, rises, rise0, last_cfg);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_pulse_seq_ctl.md
Name: tx_pulse_seq_ctl

Overview:
- Per-slot transmit sequencer for the RF front end, in the 200 MHz logic domain.
- On a slot start it takes the power amplifier to transmit, then drives one frequency-hop config per pulse from a small input FIFO.
- Each pulse gets a settle window and then an RF gate window; after the last pulse it holds the PA for a trailing guard and returns it to receive.
- It replaces free-running counter timing with an explicit FSM, underrun detection and abort.

Parameters:
SETTLE_CYC, 200, cycles between config update and RF gate rising (LO/channel settle).
OCCUPY_CYC, 1680, RF gate high duration per pulse (8.4 us).
PERIOD_CYC, 2600, pulse period in cycles (13 us); must be >= SETTLE_CYC+OCCUPY_CYC+2.
PA_LEAD, 400, PA-on cycles before first pulse LOAD.
PA_LAG, 200, PA-on cycles after the last pulse GAP.
FIFO_DEPTH, 4, hop-config FIFO entries (power of 2).

Ports:
logic_clk_in  in  1  200 MHz logic clock.
logic_rst_in  in  1  asynchronous, active-high reset.
slot_start  in  1  one-cycle pulse, start of a transmit slot.
pulse_num  in  9  pulses in the slot; sampled on an accepted slot_start.
tx_abort  in  1  level; forces termination of the current slot.
hop_vld  in  1  hop config valid.
hop_data  in  8  [2:0] channel select, [7:4] LO enable, [3] unused.
hop_rdy  out  1  FIFO not full.
tx_feq_cfg_out  out  8  current hop config.
cfg_update  out  1  one-cycle pulse when tx_feq_cfg_out changes.
rf_gate  out  1  RF transmit window (carrier on).
pa_tx_en  out  1  PA transmit (1) / receive (0).
busy  out  1  FSM not in IDLE.
pulse_idx  out  9  index of current pulse, 0-based.
underrun_err  out  1  one-cycle pulse: FIFO empty at LOAD.
overlap_err  out  1  one-cycle pulse: slot_start while busy.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM=IDLE, FIFO flushed.
  - tx_feq_cfg_out=8'h84, all other outputs 0, except hop_rdy=1 once reset is released.
- Outputs are registered; each is a Moore function of the registered state.
- FIFO:
  - Push when hop_vld && hop_rdy; hop_rdy = !full.
  - Pop only in LOAD. No bypass: an entry pushed in the same cycle LOAD samples is not visible, and an empty FIFO counts as underrun.
- IDLE:
  - slot_start && pulse_num!=0 -> PA_ON; latch pulse_num; pulse_idx=0.
  - slot_start with pulse_num==0 -> ignored, no error.
- PA_ON: pa_tx_en=1 for PA_LEAD cycles -> LOAD.
- LOAD, 1 cycle:
  - FIFO non-empty: pop into tx_feq_cfg_out, -> SETTLE.
  - FIFO empty: underrun_err=1, flush, -> PA_OFF; tx_feq_cfg_out holds its value.
- SETTLE: SETTLE_CYC cycles. cfg_update=1 in the first SETTLE cycle only. -> ON.
- ON: rf_gate=1 for OCCUPY_CYC cycles. -> GAP.
- GAP: PERIOD_CYC-1-SETTLE_CYC-OCCUPY_CYC cycles.
  - pulse_idx==pulse_num-1 -> PA_OFF.
  - Otherwise pulse_idx+1 -> LOAD.
- PA_OFF: pa_tx_en=1 for PA_LAG cycles -> IDLE (pa_tx_en=0).
- pa_tx_en=1 in every state except IDLE; busy=1 in every state except IDLE.
- tx_abort:
  - In any state other than IDLE or PA_OFF -> PA_OFF next cycle; rf_gate drops that cycle; FIFO flushed.
  - In PA_OFF: the lag runs out normally.
  - In IDLE: slot_start is blocked while tx_abort=1.
- slot_start while busy: ignored, overlap_err=1 for one cycle, the sequence is undisturbed.
- Counter widths: one 16-bit down-counter, reloaded on each state entry. pulse_idx is 9-bit and never wraps because of the pulse_num compare.
- tx_feq_cfg_out persists across slots; it is never reset except by logic_rst_in.

Test Plan (overrides SETTLE=2, OCCUPY=4, PERIOD=10, PA_LEAD=3, PA_LAG=2, cycle 0 = slot_start edge):
- Basic, 1 pulse:
  - Stimulus: FIFO preloaded 8'h21, pulse_num=1.
  - Response: pa_tx_en 1..; LOAD@4; tx_feq_cfg_out=8'h21 and cfg_update@5; rf_gate 7–10; GAP 11–13; PA_OFF 14–15; pa_tx_en=0 and busy=0@16.
- Multi-pulse:
  - Stimulus: pulse_num=3, FIFO {8'h11, 8'h42, 8'h84}.
  - Response: cfg_update @5, 15, 25 with those values; rf_gate rises @7, 17, 27; pulse_idx 0→1→2; idle @36.
- Underrun:
  - Stimulus: pulse_num=3, FIFO holds 1 entry.
  - Response: underrun_err@14; rf_gate never rises again; pa_tx_en=0@17; tx_feq_cfg_out holds the first value.
- Abort:
  - Stimulus: tx_abort at cycle 8 (mid ON).
  - Response: rf_gate=0@9; PA_OFF 9–10; idle@11; FIFO empty, hop_rdy=1.
- FIFO full / overlap:
  - Stimulus: push 5 entries back-to-back; slot_start at cycle 6 of a running slot.
  - Response: hop_rdy=0 after the 4th push, 5th not accepted; overlap_err=1 for one cycle; timing unchanged.
- Reset mid-slot:
  - Stimulus: assert logic_rst_in during ON.
  - Response: rf_gate, pa_tx_en, busy=0 immediately (asynchronous); tx_feq_cfg_out=8'h84; FIFO empty.
